// File: rtl/mcycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mcycle_ctrl_if
//  Description : Bundle between the multi-cycle controller and its datapath.
//                The master side is the controller. It receives the opcode and
//                the status flags, and it drives the strobes and mux selects.
//  Revision    : 1.0  initial release
// ============================================================================
interface mcycle_ctrl_if #(
    parameter int OPW    = 4,
    parameter int ALUOPW = 3
);
    // Datapath to controller
    logic [OPW-1:0]    opcode;
    logic              zero;
    logic              mem_ready;

    // Controller to datapath
    logic              pc_write;
    logic              ir_write;
    logic              mem_read;
    logic              mem_write;
    logic              iord;
    logic              reg_write;
    logic              reg_dst;
    logic              alu_src_a;
    logic              pc_src;
    logic [1:0]        alu_src_b;
    logic [ALUOPW-1:0] alu_op;
    logic              ext_zero;
    logic              illegal;
    logic [3:0]        state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, mem_read, mem_write, iord, reg_write,
               reg_dst, alu_src_a, pc_src, alu_src_b, alu_op, ext_zero,
               illegal, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, mem_read, mem_write, iord, reg_write,
               reg_dst, alu_src_a, pc_src, alu_src_b, alu_op, ext_zero,
               illegal, state
    );
endinterface
`default_nettype wire

// File: rtl/mcycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mcycle_ctrl
//  Description : Multi-cycle CPU control FSM. It sequences fetch, decode,
//                execute, memory and write-back states and decodes the
//                datapath strobes from the current state.
//                Optional macro MCYCLE_CTRL_MEM_WAIT_EN: when it is defined,
//                FETCH, LW_MEM and SW_MEM wait for mem_ready. When it is not
//                defined, every memory state lasts exactly one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module mcycle_ctrl #(
    parameter int OPW    = 4,
    parameter int ALUOPW = 3
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mcycle_ctrl_if.master bus
);

`ifdef MCYCLE_CTRL_MEM_WAIT_EN
    localparam bit c_MEM_WAIT = 1'b1;
`else
    localparam bit c_MEM_WAIT = 1'b0;
`endif

    localparam logic [3:0] c_OP_SHIFT   = 4'd0;
    localparam logic [3:0] c_OP_LW      = 4'd1;
    localparam logic [3:0] c_OP_SW      = 4'd2;
    localparam logic [3:0] c_OP_JUMP    = 4'd3;
    localparam logic [3:0] c_OP_BEQ     = 4'd4;
    localparam logic [3:0] c_OP_BNE     = 4'd5;
    localparam logic [3:0] c_OP_ORI     = 4'd6;
    localparam logic [3:0] c_OP_NANDI   = 4'd7;
    localparam logic [3:0] c_OP_ADD     = 4'd8;
    localparam logic [3:0] c_OP_ADDI_SE = 4'd9;
    localparam logic [3:0] c_OP_ADDI_ZE = 4'd10;
    localparam logic [3:0] c_OP_NAND    = 4'd11;
    localparam logic [3:0] c_OP_SUB     = 4'd12;
    localparam logic [3:0] c_OP_SUBI_SE = 4'd13;
    localparam logic [3:0] c_OP_SUBI_ZE = 4'd14;
    localparam logic [3:0] c_OP_OR      = 4'd15;

    localparam logic [ALUOPW-1:0] c_ALU_ADD   = ALUOPW'(0);
    localparam logic [ALUOPW-1:0] c_ALU_SUB   = ALUOPW'(1);
    localparam logic [ALUOPW-1:0] c_ALU_NAND  = ALUOPW'(2);
    localparam logic [ALUOPW-1:0] c_ALU_OR    = ALUOPW'(3);
    localparam logic [ALUOPW-1:0] c_ALU_SHIFT = ALUOPW'(4);

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_JMP    = 4'd2,
        ST_BEQ    = 4'd3,
        ST_BNE    = 4'd4,
        ST_R_EX   = 4'd5,
        ST_R_WB   = 4'd6,
        ST_MADDR  = 4'd7,
        ST_SW_MEM = 4'd8,
        ST_LW_MEM = 4'd9,
        ST_LW_WB  = 4'd10,
        ST_I_EX   = 4'd11,
        ST_I_WB   = 4'd12,
        ST_TRAP   = 4'd13
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        w_op;
    logic              w_upper_nz;
    logic              w_mem_go;
    logic [ALUOPW-1:0] w_alu_fn;
    logic              w_ext_zero_op;

    logic              w_pc_write;
    logic              w_ir_write;
    logic              w_mem_read;
    logic              w_mem_write;
    logic              w_iord;
    logic              w_reg_write;
    logic              w_reg_dst;
    logic              w_alu_src_a;
    logic              w_pc_src;
    logic [1:0]        w_alu_src_b;
    logic [ALUOPW-1:0] w_alu_op;
    logic              w_ext_zero;
    logic              w_illegal;

    assign w_op = bus.opcode[3:0];

    // A memory state may advance only when the access is complete. Without
    // the wait feature, every access counts as complete at once.
    assign w_mem_go = c_MEM_WAIT ? bus.mem_ready : 1'b1;

    // Opcode bits above [3] must be zero for a legal instruction.
    generate
        if (OPW > 4) begin : g_upper_chk
            assign w_upper_nz = |bus.opcode[OPW-1:4];
        end else begin : g_no_upper
            assign w_upper_nz = 1'b0;
        end
    endgenerate

    // Map the opcode to its ALU function and to its immediate-extension mode.
    // The opcode is stable through the instruction, so ext_zero keeps the
    // same value in I_EX and in I_WB.
    always_comb begin
        w_alu_fn      = c_ALU_ADD;
        w_ext_zero_op = 1'b0;
        case (w_op)
            c_OP_SHIFT:                  w_alu_fn = c_ALU_SHIFT;
            c_OP_SUB, c_OP_SUBI_SE,
            c_OP_BEQ, c_OP_BNE:          w_alu_fn = c_ALU_SUB;
            c_OP_SUBI_ZE: begin
                w_alu_fn      = c_ALU_SUB;
                w_ext_zero_op = 1'b1;
            end
            c_OP_NAND:                   w_alu_fn = c_ALU_NAND;
            c_OP_NANDI: begin
                w_alu_fn      = c_ALU_NAND;
                w_ext_zero_op = 1'b1;
            end
            c_OP_OR:                     w_alu_fn = c_ALU_OR;
            c_OP_ORI: begin
                w_alu_fn      = c_ALU_OR;
                w_ext_zero_op = 1'b1;
            end
            c_OP_ADDI_ZE:                w_ext_zero_op = 1'b1;
            default:                     w_alu_fn = c_ALU_ADD;
        endcase
    end

    // State register. Reset returns to FETCH from any state, including TRAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode. All outputs default to 0, so the unused
    // encodings 14 and 15 return to FETCH with every output at 0.
    always_comb begin
        w_next      = ST_FETCH;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_iord      = 1'b0;
        w_reg_write = 1'b0;
        w_reg_dst   = 1'b0;
        w_alu_src_a = 1'b0;
        w_pc_src    = 1'b0;
        w_alu_src_b = 2'b00;
        w_alu_op    = c_ALU_ADD;
        w_ext_zero  = 1'b0;
        w_illegal   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_mem_read  = 1'b1;
                w_ir_write  = w_mem_go;
                w_pc_write  = w_mem_go;
                w_alu_src_b = 2'b01;
                w_next      = w_mem_go ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                w_alu_src_b = 2'b10;
                if (w_upper_nz) begin
                    w_next = ST_TRAP;
                end else begin
                    case (w_op)
                        c_OP_JUMP:                    w_next = ST_JMP;
                        c_OP_BEQ:                     w_next = ST_BEQ;
                        c_OP_BNE:                     w_next = ST_BNE;
                        c_OP_ADD, c_OP_SUB,
                        c_OP_NAND, c_OP_OR:           w_next = ST_R_EX;
                        c_OP_LW, c_OP_SW:             w_next = ST_MADDR;
                        default:                      w_next = ST_I_EX;
                    endcase
                end
            end
            ST_JMP: begin
                w_pc_write = 1'b1;
                w_pc_src   = 1'b1;
            end
            ST_BEQ, ST_BNE: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = c_ALU_SUB;
                w_pc_src    = 1'b1;
                w_pc_write  = (r_state == ST_BEQ) ? bus.zero : ~bus.zero;
            end
            ST_R_EX: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = w_alu_fn;
                w_next      = ST_R_WB;
            end
            ST_R_WB: begin
                w_reg_write = 1'b1;
            end
            ST_MADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b11;
                w_next      = (w_op == c_OP_SW) ? ST_SW_MEM : ST_LW_MEM;
            end
            ST_SW_MEM: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
                w_next      = w_mem_go ? ST_FETCH : ST_SW_MEM;
            end
            ST_LW_MEM: begin
                w_iord     = 1'b1;
                w_mem_read = 1'b1;
                w_next     = w_mem_go ? ST_LW_WB : ST_LW_MEM;
            end
            ST_LW_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            ST_I_EX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_op    = w_alu_fn;
                w_ext_zero  = w_ext_zero_op;
                w_next      = ST_I_WB;
            end
            ST_I_WB: begin
                w_reg_write = 1'b1;
                w_ext_zero  = w_ext_zero_op;
            end
            ST_TRAP: begin
                w_illegal = 1'b1;
                w_next    = ST_TRAP;
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

    assign bus.pc_write  = w_pc_write;
    assign bus.ir_write  = w_ir_write;
    assign bus.mem_read  = w_mem_read;
    assign bus.mem_write = w_mem_write;
    assign bus.iord      = w_iord;
    assign bus.reg_write = w_reg_write;
    assign bus.reg_dst   = w_reg_dst;
    assign bus.alu_src_a = w_alu_src_a;
    assign bus.pc_src    = w_pc_src;
    assign bus.alu_src_b = w_alu_src_b;
    assign bus.alu_op    = w_alu_op;
    assign bus.ext_zero  = w_ext_zero;
    assign bus.illegal   = w_illegal;
    assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mcycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcycle_ctrl
//  Description : Self-checking bench for mcycle_ctrl. Each instruction is
//                turned into its expected state path. The expected outputs
//                for every state come from a table of the control rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mcycle_ctrl;

`ifdef MCYCLE_CTRL_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam int S_FETCH = 0, S_DECODE = 1, S_JMP = 2, S_BEQ = 3, S_BNE = 4,
                   S_R_EX = 5, S_R_WB = 6, S_MADDR = 7, S_SW_MEM = 8,
                   S_LW_MEM = 9, S_LW_WB = 10, S_I_EX = 11, S_I_WB = 12,
                   S_TRAP = 13;

    logic clk = 1'b0;
    logic rst;
    logic rst6;
    always #5 clk = ~clk;

    mcycle_ctrl_if #(.OPW(4), .ALUOPW(3)) if4 ();
    mcycle_ctrl_if #(.OPW(6), .ALUOPW(3)) if6 ();

    mcycle_ctrl #(.OPW(4), .ALUOPW(3)) dut4 (.clk(clk), .rst(rst),  .bus(if4));
    mcycle_ctrl #(.OPW(6), .ALUOPW(3)) dut6 (.clk(clk), .rst(rst6), .bus(if6));

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] obs4;
    logic [15:0] obs6;
    assign obs4 = {if4.pc_write, if4.ir_write, if4.mem_read, if4.mem_write, if4.iord,
                   if4.reg_write, if4.reg_dst, if4.alu_src_a, if4.pc_src,
                   if4.alu_src_b, if4.alu_op, if4.ext_zero, if4.illegal};
    assign obs6 = {if6.pc_write, if6.ir_write, if6.mem_read, if6.mem_write, if6.iord,
                   if6.reg_write, if6.reg_dst, if6.alu_src_a, if6.pc_src,
                   if6.alu_src_b, if6.alu_op, if6.ext_zero, if6.illegal};

    // ALU function for each opcode: add=0 sub=1 nand=2 or=3 shift=4
    function automatic logic [2:0] alu_of(input logic [3:0] op);
        case (op)
            4'd0:                      return 3'd4;
            4'd12, 4'd13, 4'd14:       return 3'd1;
            4'd7, 4'd11:               return 3'd2;
            4'd6, 4'd15:               return 3'd3;
            default:                   return 3'd0;
        endcase
    endfunction

    // Expected output vector for one state of one instruction
    function automatic logic [15:0] exp_out(input int st, input logic [3:0] op,
                                            input logic z, input logic mr);
        logic pcw, irw, mrd, mwr, iord, rw, rd, asa, pcs, ez, ill;
        logic [1:0] sb;
        logic [2:0] ao;
        {pcw, irw, mrd, mwr, iord, rw, rd, asa, pcs, ez, ill} = '0;
        sb = 2'b00;
        ao = 3'd0;
        case (st)
            S_FETCH:  begin mrd = 1; irw = WAIT_EN ? mr : 1'b1; pcw = irw; sb = 2'b01; end
            S_DECODE: sb = 2'b10;
            S_JMP:    begin pcw = 1; pcs = 1; end
            S_BEQ:    begin asa = 1; ao = 3'd1; pcs = 1; pcw = z; end
            S_BNE:    begin asa = 1; ao = 3'd1; pcs = 1; pcw = ~z; end
            S_R_EX:   begin asa = 1; ao = alu_of(op); end
            S_R_WB:   rw = 1;
            S_MADDR:  begin asa = 1; sb = 2'b11; end
            S_SW_MEM: begin iord = 1; mwr = 1; end
            S_LW_MEM: begin iord = 1; mrd = 1; end
            S_LW_WB:  begin rw = 1; rd = 1; end
            S_I_EX:   begin asa = 1; sb = 2'b10; ao = alu_of(op);
                            ez = (op inside {4'd6, 4'd7, 4'd10, 4'd14}); end
            S_I_WB:   begin rw = 1; ez = (op inside {4'd6, 4'd7, 4'd10, 4'd14}); end
            S_TRAP:   ill = 1;
            default:  ;
        endcase
        return {pcw, irw, mrd, mwr, iord, rw, rd, asa, pcs, sb, ao, ez, ill};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one instruction on dut4, starting in FETCH.
    // zmode: 0/1 force zero, 2 random.
    // lw_stall: number of mem_ready-low cycles in LW_MEM.
    // rst_at: cycle index at which reset is applied (-1 for none).
    task automatic run_instr(input logic [3:0] op, input int zmode, input bit mr_rand,
                             input int lw_stall, input int rst_at);
        int   path[$];
        int   idx   = 0;
        int   cyc   = 0;
        int   stall = lw_stall;
        int   st;
        logic z, mr;
        path = '{S_FETCH, S_DECODE};
        case (op)
            4'd3:                      path.push_back(S_JMP);
            4'd4:                      path.push_back(S_BEQ);
            4'd5:                      path.push_back(S_BNE);
            4'd8, 4'd11, 4'd12, 4'd15: begin path.push_back(S_R_EX); path.push_back(S_R_WB); end
            4'd1: begin path.push_back(S_MADDR); path.push_back(S_LW_MEM); path.push_back(S_LW_WB); end
            4'd2: begin path.push_back(S_MADDR); path.push_back(S_SW_MEM); end
            default:                   begin path.push_back(S_I_EX); path.push_back(S_I_WB); end
        endcase
        if4.opcode = op;
        while (idx < path.size() && cyc < 64) begin
            st = path[idx];
            if (st == S_LW_MEM && stall > 0) begin
                mr = 1'b0;
                stall--;
            end else begin
                mr = mr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            if4.zero      = z;
            if4.mem_ready = mr;
            if (cyc == rst_at) rst = 1'b1;
            @(negedge clk);
            check("state", 16'(if4.state), 16'(st));
            check("outputs", obs4, exp_out(st, op, z, mr));
            @(posedge clk);
            #1;
            if (cyc == rst_at) begin
                rst = 1'b0;
                break;
            end
            if (!(WAIT_EN && (st inside {S_FETCH, S_LW_MEM, S_SW_MEM}) && !mr)) idx++;
            cyc++;
        end
        n_vec++;
        assert (cyc < 64) else begin
            n_err++;
            $error("FAIL timeout: observed %0d cycles expected < 64", cyc);
        end
    endtask

    initial begin
        rst           = 1'b1;
        rst6          = 1'b1;
        if4.opcode    = '0;
        if4.zero      = 1'b0;
        if4.mem_ready = 1'b1;
        if6.opcode    = '0;
        if6.zero      = 1'b0;
        if6.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        @(negedge clk);
        check("reset_state", 16'(if4.state), 16'(S_FETCH));
        check("reset_outputs", obs4, exp_out(S_FETCH, 4'd0, 1'b0, 1'b1));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed instructions
        run_instr(4'd8, 2, 1'b0, 0, -1);          // add
        run_instr(4'd4, 1, 1'b0, 0, -1);          // beq, taken
        run_instr(4'd4, 0, 1'b0, 0, -1);          // beq, not taken
        run_instr(4'd5, 1, 1'b0, 0, -1);          // bne, not taken
        run_instr(4'd5, 0, 1'b0, 0, -1);          // bne, taken
        run_instr(4'd1, 2, 1'b0, 3, -1);          // lw with stalled memory
        run_instr(4'd10, 2, 1'b0, 0, -1);         // addi_ze
        for (int o = 0; o < 16; o++) run_instr(4'(o), 2, 1'b0, 0, -1);
        run_instr(4'd2, 2, 1'b0, 0, 3);           // reset while in SW_MEM
        run_instr(4'd2, 2, 1'b0, 0, -1);          // first cycle checks FETCH, mem_write=0

        // Random instructions, random handshakes and occasional resets
        for (int k = 0; k < 60; k++) begin
            run_instr(4'($urandom_range(0, 15)), 2, 1'b1, $urandom_range(0, 3),
                      ($urandom_range(0, 4) == 0) ? $urandom_range(0, 5) : -1);
        end

        // Illegal opcode on the wide-opcode instance
        rst           = 1'b1;
        if6.opcode    = 6'b010000;
        if6.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        rst6 = 1'b0;
        @(negedge clk);
        check("w_fetch", 16'(if6.state), 16'(S_FETCH));
        check("w_fetch_out", obs6, exp_out(S_FETCH, 4'd0, 1'b0, 1'b1));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("w_decode", 16'(if6.state), 16'(S_DECODE));
        @(posedge clk);
        #1;
        for (int t = 0; t < 10; t++) begin
            if6.zero      = 1'($urandom_range(0, 1));
            if6.mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("trap_state", 16'(if6.state), 16'(S_TRAP));
            check("trap_out", obs6, exp_out(S_TRAP, 4'd0, 1'b0, 1'b0));
            @(posedge clk);
            #1;
        end
        if6.mem_ready = 1'b1;
        rst6 = 1'b1;
        @(posedge clk);
        #1;
        rst6       = 1'b0;
        if6.opcode = 6'd8;
        @(negedge clk);
        check("trap_reset", 16'(if6.state), 16'(S_FETCH));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("w_rex", 16'(if6.state), 16'(S_R_EX));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
